// File: rtl/timer_pkg.sv
// Shared constants for the timer block.
//   CNT_W       : width of the free-running counter
//   DIV_MAX     : largest honoured prescaler exponent
//   PRESC_W     : prescaler counter width
//   DIV_VAL_RST : reset value of the divider exponent, mirrors the register block
package timer_pkg;

  localparam int CNT_W   = 64;
  localparam int DIV_MAX = 8;
  localparam int PRESC_W = 8;

  localparam logic [3:0] DIV_VAL_RST = 4'd1;

endpackage

// File: rtl/timer_counter_if.sv
// Bundle between the timer register block (master) and the counter (slave).
//   timer_en, div_en, div_val       : counting / prescaler configuration
//   halt_req, dbg_mode              : debug halt request and system debug state
//   tdr0_wr_sel, tdr1_wr_sel        : low / high half load strobes
//   wdata_cnt                       : load data
//   cnt, halt_ack, cnt_ovf          : counter value, halt acknowledge, wrap pulse
interface timer_counter_if;
  import timer_pkg::CNT_W;

  logic             timer_en;
  logic             div_en;
  logic [3:0]       div_val;
  logic             halt_req;
  logic             dbg_mode;
  logic             tdr0_wr_sel;
  logic             tdr1_wr_sel;
  logic [31:0]      wdata_cnt;
  logic [CNT_W-1:0] cnt;
  logic             halt_ack;
  logic             cnt_ovf;

  modport master (
    output timer_en, div_en, div_val, halt_req, dbg_mode,
           tdr0_wr_sel, tdr1_wr_sel, wdata_cnt,
    input  cnt, halt_ack, cnt_ovf
  );

  modport slave (
    input  timer_en, div_en, div_val, halt_req, dbg_mode,
           tdr0_wr_sel, tdr1_wr_sel, wdata_cnt,
    output cnt, halt_ack, cnt_ovf
  );

endinterface

// File: rtl/timer_prescaler.sv
// Power-of-two prescaler producing the counter tick.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   timer_en           : counting enable, clears the prescaler when low
//   halt               : debug freeze, holds the prescaler
//   div_en, div_val    : prescaler enable and exponent (clamped to DIV_MAX)
//   tick               : counter may advance this cycle
module timer_prescaler
  import timer_pkg::DIV_VAL_RST;
#(
  parameter int DIV_MAX = timer_pkg::DIV_MAX,
  parameter int PRESC_W = timer_pkg::PRESC_W
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       timer_en,
  input  logic       halt,
  input  logic       div_en,
  input  logic [3:0] div_val,
  output logic       tick
);

  logic [PRESC_W-1:0] presc;
  logic               div_en_q;
  logic [3:0]         div_val_q;
  logic [3:0]         k;
  logic [PRESC_W-1:0] terminal;
  logic               cfg_changed;
  logic               at_terminal;

  always_comb begin
    k = div_val;
    if (int'(div_val) > DIV_MAX) k = DIV_MAX[3:0];
  end

  assign terminal    = PRESC_W'((32'd1 << k) - 32'd1);
  assign at_terminal = (presc == terminal);

  // Any divider reprogramming restarts the interval and suppresses this
  // cycle's tick, so a half-finished interval from the old divisor is dropped.
  assign cfg_changed = (div_en != div_en_q) || (div_val != div_val_q);
  assign tick        = !cfg_changed && (!div_en || at_terminal);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc     <= '0;
      div_en_q  <= 1'b0;
      div_val_q <= DIV_VAL_RST;
    end else begin
      div_en_q  <= div_en;
      div_val_q <= div_val;
      if (!timer_en || cfg_changed) begin
        presc <= '0;
      end else if (halt) begin
        presc <= presc;
      end else if (div_en) begin
        presc <= at_terminal ? '0 : presc + 1'b1;
      end else begin
        presc <= '0;
      end
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Free-running 64-bit counter with prescaler, half-word loads and debug halt.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   bus (slave)        : configuration/load inputs, cnt/halt_ack/cnt_ovf outputs
module timer_counter
  import timer_pkg::CNT_W;
#(
  parameter int DIV_MAX = timer_pkg::DIV_MAX,
  parameter int PRESC_W = timer_pkg::PRESC_W
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  timer_counter_if.slave bus
);

  logic [CNT_W-1:0] cnt_q;
  logic             halt_ack_q;
  logic             cnt_ovf_q;
  logic             halt;
  logic             tick;
  logic             load;
  logic             inc;

  // Combinational so the counter freezes in the very cycle halt is asserted.
  assign halt = bus.halt_req & bus.dbg_mode;
  assign load = bus.tdr0_wr_sel | bus.tdr1_wr_sel;
  assign inc  = bus.timer_en & ~halt & tick & ~load;

  timer_prescaler #(
    .DIV_MAX (DIV_MAX),
    .PRESC_W (PRESC_W)
  ) u_presc (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .timer_en  (bus.timer_en),
    .halt      (halt),
    .div_en    (bus.div_en),
    .div_val   (bus.div_val),
    .tick      (tick)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q      <= '0;
      cnt_ovf_q  <= 1'b0;
      halt_ack_q <= 1'b0;
    end else begin
      halt_ack_q <= halt;
      // Loads never count as a wrap, only a real increment out of all-ones.
      cnt_ovf_q  <= inc & (&cnt_q);
      if (load) begin
        if (bus.tdr0_wr_sel) cnt_q[31:0]  <= bus.wdata_cnt;
        if (bus.tdr1_wr_sel) cnt_q[63:32] <= bus.wdata_cnt;
      end else if (inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.cnt      = cnt_q;
  assign bus.halt_ack = halt_ack_q;
  assign bus.cnt_ovf  = cnt_ovf_q;

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

  localparam int DMAX = 8;

  logic sys_clk;
  logic sys_rst_n;
  int   n_checks;
  int   n_fail;

  timer_counter_if bus();

  timer_counter #(.DIV_MAX(DMAX), .PRESC_W(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Reference model: counted edges within the current prescale interval,
  // plus the last divider configuration seen, to detect reprogramming.
  logic [63:0] m_cnt;
  int          m_elapsed;
  logic        m_en_seen;
  logic [3:0]  m_val_seen;
  logic        m_ovf;
  logic        m_ack;

  task automatic model_reset();
    m_cnt      = '0;
    m_elapsed  = 0;
    m_en_seen  = 1'b0;
    m_val_seen = 4'd1;
    m_ovf      = 1'b0;
    m_ack      = 1'b0;
  endtask

  task automatic model_step();
    logic changed, halt, tick, inc, wr;
    int   divisor;
    changed = (bus.div_en != m_en_seen) || (bus.div_val != m_val_seen);
    halt    = bus.halt_req && bus.dbg_mode;
    divisor = 1 << ((int'(bus.div_val) > DMAX) ? DMAX : int'(bus.div_val));
    tick    = !changed && (!bus.div_en || (m_elapsed + 1 == divisor));
    wr      = bus.tdr0_wr_sel || bus.tdr1_wr_sel;
    inc     = bus.timer_en && !halt && tick && !wr;
    m_ovf   = inc && (m_cnt == 64'hFFFF_FFFF_FFFF_FFFF);
    if (wr) begin
      if (bus.tdr0_wr_sel) m_cnt[31:0]  = bus.wdata_cnt;
      if (bus.tdr1_wr_sel) m_cnt[63:32] = bus.wdata_cnt;
    end else if (inc) begin
      m_cnt = m_cnt + 64'd1;
    end
    if (!bus.timer_en || changed) m_elapsed = 0;
    else if (!halt) m_elapsed = (bus.div_en && !tick) ? m_elapsed + 1 : 0;
    m_ack      = halt;
    m_en_seen  = bus.div_en;
    m_val_seen = bus.div_val;
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
  endtask

  task automatic clear_writes();
    bus.tdr0_wr_sel = 1'b0;
    bus.tdr1_wr_sel = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    model_reset();
    n_checks += 3;
    if (bus.cnt !== 64'd0) begin n_fail++; $display("FAIL reset_cnt got=%h exp=0", bus.cnt); end
    if (bus.halt_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", bus.halt_ack); end
    if (bus.cnt_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", bus.cnt_ovf); end
    sys_rst_n = 1'b1;
    cycle();
    n_checks++;
    if (bus.cnt !== 64'd0) begin n_fail++; $display("FAIL reset_idle_cnt got=%h exp=0", bus.cnt); end
  endtask

  task automatic test_free_run();
    bus.timer_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      n_checks += 3;
      if (bus.cnt !== 64'(i)) begin n_fail++; $display("FAIL free_cnt i=%0d got=%h exp=%h", i, bus.cnt, 64'(i)); end
      if (bus.halt_ack !== 1'b0) begin n_fail++; $display("FAIL free_ack i=%0d got=%b exp=0", i, bus.halt_ack); end
      if (bus.cnt_ovf !== 1'b0) begin n_fail++; $display("FAIL free_ovf i=%0d got=%b exp=0", i, bus.cnt_ovf); end
    end
  endtask

  task automatic test_prescale();
    int n;
    bus.timer_en = 1'b0;
    bus.div_en = 1'b1;
    bus.div_val = 4'd2;
    bus.tdr0_wr_sel = 1'b1;
    bus.tdr1_wr_sel = 1'b1;
    bus.wdata_cnt = 32'd0;
    cycle();
    clear_writes();
    bus.timer_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cycle();
      n_checks += 2;
      if (bus.cnt !== 64'(i / 4)) begin n_fail++; $display("FAIL presc_cnt i=%0d got=%h exp=%h", i, bus.cnt, 64'(i / 4)); end
      if (bus.cnt !== m_cnt) begin n_fail++; $display("FAIL presc_model i=%0d got=%h exp=%h", i, bus.cnt, m_cnt); end
    end
    repeat (2) cycle();
    bus.div_val = 4'd3;
    cycle();
    n = 0;
    while (bus.cnt == 64'd4 && n < 20) begin
      cycle();
      n++;
    end
    n_checks += 2;
    if (n != 8) begin n_fail++; $display("FAIL divchg_latency got=%0d exp=8", n); end
    if (bus.cnt !== 64'd5) begin n_fail++; $display("FAIL divchg_cnt got=%h exp=5", bus.cnt); end
  endtask

  task automatic test_overflow();
    bus.div_en = 1'b0;
    bus.tdr1_wr_sel = 1'b1;
    bus.wdata_cnt = 32'hFFFF_FFFF;
    cycle();
    bus.tdr1_wr_sel = 1'b0;
    bus.tdr0_wr_sel = 1'b1;
    bus.wdata_cnt = 32'hFFFF_FFFE;
    cycle();
    clear_writes();
    n_checks += 2;
    if (bus.cnt !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL ovf_load got=%h exp=fffffffffffffffe", bus.cnt); end
    if (bus.cnt_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_load_pulse got=%b exp=0", bus.cnt_ovf); end
    cycle();
    n_checks += 2;
    if (bus.cnt !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL ovf_ones got=%h exp=ffffffffffffffff", bus.cnt); end
    if (bus.cnt_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early got=%b exp=0", bus.cnt_ovf); end
    cycle();
    n_checks += 2;
    if (bus.cnt !== 64'd0) begin n_fail++; $display("FAIL ovf_wrap got=%h exp=0", bus.cnt); end
    if (bus.cnt_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got=%b exp=1", bus.cnt_ovf); end
    cycle();
    n_checks += 2;
    if (bus.cnt !== 64'd1) begin n_fail++; $display("FAIL ovf_after got=%h exp=1", bus.cnt); end
    if (bus.cnt_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_width got=%b exp=0", bus.cnt_ovf); end
  endtask

  task automatic test_halt();
    logic [63:0] v;
    repeat (2) cycle();
    v = m_cnt;
    bus.dbg_mode = 1'b1;
    bus.halt_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks += 2;
      if (bus.cnt !== v) begin n_fail++; $display("FAIL halt_freeze i=%0d got=%h exp=%h", i, bus.cnt, v); end
      if (bus.halt_ack !== 1'b1) begin n_fail++; $display("FAIL halt_ack i=%0d got=%b exp=1", i, bus.halt_ack); end
    end
    bus.halt_req = 1'b0;
    cycle();
    n_checks += 2;
    if (bus.halt_ack !== 1'b0) begin n_fail++; $display("FAIL halt_release_ack got=%b exp=0", bus.halt_ack); end
    if (bus.cnt !== v + 64'd1) begin n_fail++; $display("FAIL halt_resume got=%h exp=%h", bus.cnt, v + 64'd1); end
    bus.halt_req = 1'b1;
    bus.dbg_mode = 1'b0;
    cycle();
    n_checks += 2;
    if (bus.cnt !== v + 64'd2) begin n_fail++; $display("FAIL halt_nodbg got=%h exp=%h", bus.cnt, v + 64'd2); end
    if (bus.halt_ack !== 1'b0) begin n_fail++; $display("FAIL halt_nodbg_ack got=%b exp=0", bus.halt_ack); end
    bus.halt_req = 1'b0;
  endtask

  task automatic test_load_tick();
    bus.tdr1_wr_sel = 1'b1;
    bus.wdata_cnt = 32'h5;
    cycle();
    bus.tdr1_wr_sel = 1'b0;
    bus.tdr0_wr_sel = 1'b1;
    bus.wdata_cnt = 32'hFF;
    cycle();
    n_checks++;
    if (bus.cnt !== 64'h5_0000_00FF) begin n_fail++; $display("FAIL load_setup got=%h exp=5000000ff", bus.cnt); end
    bus.wdata_cnt = 32'h100;
    cycle();
    n_checks++;
    if (bus.cnt !== 64'h5_0000_0100) begin n_fail++; $display("FAIL load_tick got=%h exp=500000100", bus.cnt); end
    cycle();
    n_checks++;
    if (bus.cnt !== 64'h5_0000_0100) begin n_fail++; $display("FAIL load_noinc got=%h exp=500000100", bus.cnt); end
    clear_writes();
    cycle();
    n_checks++;
    if (bus.cnt !== 64'h5_0000_0101) begin n_fail++; $display("FAIL load_resume got=%h exp=500000101", bus.cnt); end
  endtask

  task automatic test_clamp();
    bus.timer_en = 1'b0;
    bus.div_en = 1'b1;
    bus.div_val = 4'd15;
    bus.tdr0_wr_sel = 1'b1;
    bus.tdr1_wr_sel = 1'b1;
    bus.wdata_cnt = 32'd0;
    cycle();
    clear_writes();
    bus.timer_en = 1'b1;
    for (int i = 1; i <= 512; i++) begin
      cycle();
      if (i == 255 || i == 256 || i == 511 || i == 512) begin
        n_checks++;
        if (bus.cnt !== 64'(i / 256)) begin n_fail++; $display("FAIL clamp i=%0d got=%h exp=%h", i, bus.cnt, 64'(i / 256)); end
      end
    end
  endtask

  task automatic test_async_reset();
    bus.div_val = 4'd1;
    repeat (3) cycle();
    #2 sys_rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (bus.cnt !== 64'd0) begin n_fail++; $display("FAIL arst_cnt got=%h exp=0", bus.cnt); end
    if (bus.halt_ack !== 1'b0) begin n_fail++; $display("FAIL arst_ack got=%b exp=0", bus.halt_ack); end
    if (bus.cnt_ovf !== 1'b0) begin n_fail++; $display("FAIL arst_ovf got=%b exp=0", bus.cnt_ovf); end
    model_reset();
    @(negedge sys_clk);
    bus.div_en = 1'b0;
    sys_rst_n = 1'b1;
    cycle();
    n_checks++;
    if (bus.cnt !== 64'd1) begin n_fail++; $display("FAIL arst_first got=%h exp=1", bus.cnt); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      bus.timer_en    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) bus.div_en = ~bus.div_en;
      if ($urandom_range(0, 29) == 0)
        bus.div_val = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 3));
      bus.halt_req    = ($urandom_range(0, 7) == 0);
      bus.dbg_mode    = ($urandom_range(0, 3) != 0);
      bus.tdr0_wr_sel = ($urandom_range(0, 39) == 0);
      bus.tdr1_wr_sel = ($urandom_range(0, 39) == 0);
      bus.wdata_cnt   = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
      cycle();
      n_checks += 3;
      if (bus.cnt !== m_cnt) begin n_fail++; $display("FAIL rand_cnt c=%0d got=%h exp=%h", c, bus.cnt, m_cnt); end
      if (bus.cnt_ovf !== m_ovf) begin n_fail++; $display("FAIL rand_ovf c=%0d got=%b exp=%b", c, bus.cnt_ovf, m_ovf); end
      if (bus.halt_ack !== m_ack) begin n_fail++; $display("FAIL rand_ack c=%0d got=%b exp=%b", c, bus.halt_ack, m_ack); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    sys_rst_n = 1'b0;
    bus.timer_en = 1'b0;
    bus.div_en = 1'b0;
    bus.div_val = 4'd1;
    bus.halt_req = 1'b0;
    bus.dbg_mode = 1'b0;
    bus.tdr0_wr_sel = 1'b0;
    bus.tdr1_wr_sel = 1'b0;
    bus.wdata_cnt = 32'd0;
    model_reset();
    test_reset();
    test_free_run();
    test_prescale();
    test_overflow();
    test_halt();
    test_load_tick();
    test_clamp();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
